// File: rtl/first_nios2_system_sysid_check_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
// Holds the FSM state encoding, the word addresses and the timeout counter width.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ID_REQ  = 3'd1,
        RD_ID_WAIT = 3'd2,
        RD_TS_REQ  = 3'd3,
        RD_TS_WAIT = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int CNT_W = 16;

    function automatic logic is_req(input state_t s);
        return (s == RD_ID_REQ) || (s == RD_TS_REQ);
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == RD_ID_REQ) || (s == RD_ID_WAIT) ||
               (s == RD_TS_REQ) || (s == RD_TS_WAIT);
    endfunction

endpackage

// File: rtl/first_nios2_system_sysid_check_if.sv
// Avalon-MM read-only bus between the checker (master) and the system ID slave.
interface first_nios2_system_sysid_check_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/first_nios2_system_sysid_check_timer.sv
// Per-transaction timeout counter: cleared on entry to a request, counts while enabled.
// terminal fires in the cycle whose increment would reach TIMEOUT_CYCLES.
module sysid_check_timer
    import sysid_check_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] TERM_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Firing one count early lets the FSM register DONE on the same edge the
    // count reaches TIMEOUT_CYCLES, so every output stays a plain register.
    assign terminal = enable && (count_reg == TERM_VALUE);

endmodule

// File: rtl/first_nios2_system_sysid_check.sv
// Reads the system ID word and build timestamp over Avalon-MM and compares both
// against build-time constants; results gate LED status and boot-loader release.
module first_nios2_system_sysid_check
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h56B5_E450,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    first_nios2_system_sysid_check_if.master avm,
    output logic                             busy,
    output logic                             done,
    output logic                             id_ok,
    output logic                             ts_ok,
    output logic                             timeout,
    output logic [31:0]                      id_value,
    output logic [31:0]                      ts_value
);

    state_t      state_reg, state_next;
    logic        avm_read_reg, avm_read_next;
    logic        avm_address_reg, avm_address_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        id_ok_reg, id_ok_next;
    logic        ts_ok_reg, ts_ok_next;
    logic        timeout_reg, timeout_next;
    logic [31:0] id_value_reg, id_value_next;
    logic [31:0] ts_value_reg, ts_value_next;

    logic timer_clear;
    logic timer_enable;
    logic timer_terminal;

    sysid_check_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .terminal(timer_terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        id_ok_next    = id_ok_reg;
        ts_ok_next    = ts_ok_reg;
        timeout_next  = timeout_reg;
        id_value_next = id_value_reg;
        ts_value_next = ts_value_reg;
        timer_enable  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start || AUTO_START) begin
                    state_next = RD_ID_REQ;
                end
            end
            // In request states a timeout wins over a late acceptance, so a
            // transaction can never slip past the terminal count.
            RD_ID_REQ: begin
                timer_enable = 1'b1;
                if (timer_terminal) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end else if (!avm.avm_waitrequest) begin
                    state_next = RD_ID_WAIT;
                end
            end
            RD_ID_WAIT: begin
                timer_enable = 1'b1;
                if (avm.avm_readdatavalid) begin
                    id_value_next = avm.avm_readdata;
                    id_ok_next    = (avm.avm_readdata == EXPECTED_ID);
                    state_next    = RD_TS_REQ;
                end else if (timer_terminal) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end
            end
            RD_TS_REQ: begin
                timer_enable = 1'b1;
                if (timer_terminal) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end else if (!avm.avm_waitrequest) begin
                    state_next = RD_TS_WAIT;
                end
            end
            RD_TS_WAIT: begin
                timer_enable = 1'b1;
                if (avm.avm_readdatavalid) begin
                    ts_value_next = avm.avm_readdata;
                    ts_ok_next    = (avm.avm_readdata == EXPECTED_TS);
                    state_next    = DONE;
                end else if (timer_terminal) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    id_ok_next    = 1'b0;
                    ts_ok_next    = 1'b0;
                    timeout_next  = 1'b0;
                    id_value_next = '0;
                    ts_value_next = '0;
                    state_next    = RD_ID_REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        timer_clear = is_req(state_next) && (state_next != state_reg);

        // Bus and status outputs are registered from the next state so they
        // line up with the state they describe without an extra cycle.
        avm_read_next    = is_req(state_next);
        avm_address_next = ((state_next == RD_TS_REQ) || (state_next == RD_TS_WAIT))
                           ? ADDR_TS : ADDR_ID;
        busy_next        = is_busy(state_next);
        done_next        = (state_next == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avm_read_reg    <= 1'b0;
            avm_address_reg <= ADDR_ID;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            id_ok_reg       <= 1'b0;
            ts_ok_reg       <= 1'b0;
            timeout_reg     <= 1'b0;
            id_value_reg    <= '0;
            ts_value_reg    <= '0;
        end else begin
            avm_read_reg    <= avm_read_next;
            avm_address_reg <= avm_address_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            id_ok_reg       <= id_ok_next;
            ts_ok_reg       <= ts_ok_next;
            timeout_reg     <= timeout_next;
            id_value_reg    <= id_value_next;
            ts_value_reg    <= ts_value_next;
        end
    end

    assign avm.avm_read    = avm_read_reg;
    assign avm.avm_address = avm_address_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign id_ok           = id_ok_reg;
    assign ts_ok           = ts_ok_reg;
    assign timeout         = timeout_reg;
    assign id_value        = id_value_reg;
    assign ts_value        = ts_value_reg;

endmodule

// File: tb/tb_first_nios2_system_sysid_check.sv
// Self-checking bench: behavioural Avalon slave plus a scoreboard of expected
// check results, compared when the checker raises done.
module tb_first_nios2_system_sysid_check;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h56B5_E450;
    localparam int          TO_CYC = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    first_nios2_system_sysid_check_if avm_bus();

    first_nios2_system_sysid_check #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TO_CYC),
        .AUTO_START    (1'b1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .avm     (avm_bus),
        .busy    (busy),
        .done    (done),
        .id_ok   (id_ok),
        .ts_ok   (ts_ok),
        .timeout (timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        int          done_cyc;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        logic [31:0] id_value;
        logic [31:0] ts_value;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    // Cycle number relative to the start of the current run (1 = first read cycle).
    int rel_cyc = 0;
    bit mark    = 1'b0;

    // Slave behaviour knobs and state
    int          stall_cycles = 0;
    int          latency      = 1;
    bit          drop_id      = 1'b0;
    bit          hold_off     = 1'b0;
    logic [31:0] slv_id       = EXP_ID;
    logic [31:0] slv_ts       = EXP_TS;
    int          stall_cnt    = 0;
    bit          pend         = 1'b0;
    int          pend_delay   = 0;
    logic [31:0] pend_data    = '0;
    int          rd_cnt_id    = 0;
    int          rd_cnt_ts    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int cyc, input logic iok, input logic tok, input logic to,
                            input logic [31:0] idv, input logic [31:0] tsv);
        exp_t e;
        e.done_cyc = cyc;
        e.id_ok    = iok;
        e.ts_ok    = tok;
        e.timeout  = to;
        e.id_value = idv;
        e.ts_value = tsv;
        sb.push_back(e);
    endtask

    task automatic pulse_start(input bit expect_accept);
        start = 1'b1;
        mark  = expect_accept;
        @(negedge clock);
        start = 1'b0;
        mark  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 32'(done === 1'b1), 32'd1);
    endtask

    task automatic wait_rel(input int cyc);
        int n = 0;
        while (rel_cyc != cyc && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("wait_rel", 32'(rel_cyc), 32'(cyc));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},     32'(busy),                 32'd0);
        check_eq({tag, "_done"},     32'(done),                 32'd0);
        check_eq({tag, "_id_ok"},    32'(id_ok),                32'd0);
        check_eq({tag, "_ts_ok"},    32'(ts_ok),                32'd0);
        check_eq({tag, "_timeout"},  32'(timeout),              32'd0);
        check_eq({tag, "_id_value"}, id_value,                  32'd0);
        check_eq({tag, "_ts_value"}, ts_value,                  32'd0);
        check_eq({tag, "_read"},     32'(avm_bus.avm_read),     32'd0);
        check_eq({tag, "_address"},  32'(avm_bus.avm_address),  32'd0);
    endtask

    initial forever begin
        @(posedge clock);
        if (reset)     rel_cyc = 0;
        else if (mark) rel_cyc = 1;
        else           rel_cyc++;
    end

    // Avalon slave: responds at the falling edge so the DUT samples stable inputs.
    initial begin
        avm_bus.avm_waitrequest   = 1'b0;
        avm_bus.avm_readdata      = '0;
        avm_bus.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clock);
            avm_bus.avm_readdatavalid = 1'b0;
            if (pend) begin
                if (pend_delay == 0) begin
                    avm_bus.avm_readdatavalid = 1'b1;
                    avm_bus.avm_readdata      = pend_data;
                    pend = 1'b0;
                end else begin
                    pend_delay--;
                end
            end
            if (avm_bus.avm_read === 1'b1) begin
                if (avm_bus.avm_address) rd_cnt_ts++;
                else                     rd_cnt_id++;
                if (hold_off || stall_cnt < stall_cycles) begin
                    avm_bus.avm_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    avm_bus.avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                    if (!(drop_id && !avm_bus.avm_address)) begin
                        pend       = 1'b1;
                        pend_delay = latency - 1;
                        pend_data  = avm_bus.avm_address ? slv_ts : slv_id;
                    end
                end
            end else begin
                avm_bus.avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: one comparison set per rising edge of done.
    initial begin
        bit   done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (done === 1'b1 && !done_q) begin
                n_txn++;
                $display("txn %0d: cycle=%0d id=0x%08h ts=0x%08h id_ok=%0b ts_ok=%0b timeout=%0b",
                         n_txn, rel_cyc, id_value, ts_value, id_ok, ts_ok, timeout);
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("done_cycle", 32'(rel_cyc),  32'(e.done_cyc));
                    check_eq("id_ok",      32'(id_ok),    32'(e.id_ok));
                    check_eq("ts_ok",      32'(ts_ok),    32'(e.ts_ok));
                    check_eq("timeout",    32'(timeout),  32'(e.timeout));
                    check_eq("id_value",   id_value,      e.id_value);
                    check_eq("ts_value",   ts_value,      e.ts_value);
                end
            end
            done_q = (done === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset");

        // Auto-started nominal check: zero stall, latency 1
        push_exp(5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        reset = 1'b0;
        wait_done("run1_done");
        @(negedge clock);

        // Wrong timestamp; start in DONE must clear results on the next cycle
        slv_ts = EXP_TS + 32'd1;
        push_exp(5, 1'b1, 1'b0, 1'b0, EXP_ID, EXP_TS + 32'd1);
        pulse_start(1'b1);
        check_eq("clr_done",     32'(done),             32'd0);
        check_eq("clr_ts_ok",    32'(ts_ok),            32'd0);
        check_eq("clr_id_ok",    32'(id_ok),            32'd0);
        check_eq("clr_ts_value", ts_value,              32'd0);
        check_eq("start_busy",   32'(busy),             32'd1);
        check_eq("start_read",   32'(avm_bus.avm_read), 32'd1);
        wait_done("run2_done");
        @(negedge clock);

        // Three stall cycles per read: request held for four cycles each
        slv_ts       = EXP_TS;
        stall_cycles = 3;
        rd_cnt_id    = 0;
        rd_cnt_ts    = 0;
        push_exp(11, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        pulse_start(1'b1);
        wait_done("run3_done");
        check_eq("stall_rd_id_cycles", 32'(rd_cnt_id), 32'd4);
        check_eq("stall_rd_ts_cycles", 32'(rd_cnt_ts), 32'd4);
        stall_cycles = 0;
        @(negedge clock);

        // ID read never answered: timeout after TO_CYC cycles
        drop_id = 1'b1;
        push_exp(TO_CYC + 1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        pulse_start(1'b1);
        wait_done("run4_done");
        check_eq("to_read_low", 32'(avm_bus.avm_read), 32'd0);
        check_eq("to_busy_low", 32'(busy),             32'd0);
        drop_id = 1'b0;
        @(negedge clock);

        // Latency 3; start pulsed during the timestamp wait is ignored
        latency = 3;
        push_exp(9, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        pulse_start(1'b1);
        wait_rel(6);
        pulse_start(1'b0);
        check_eq("ign_busy",    32'(busy),                32'd1);
        check_eq("ign_address", 32'(avm_bus.avm_address), 32'd1);
        wait_done("run5_done");
        @(negedge clock);

        // Reset during the ID wait; the in-flight response must not be captured
        slv_id = 32'hDEAD_BEEF;
        pulse_start(1'b1);
        wait_rel(2);
        reset    = 1'b1;
        hold_off = 1'b1;
        @(negedge clock);
        check_all_zero("midrst");
        push_exp(TO_CYC + 1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        reset = 1'b0;
        wait_done("run6_done");
        hold_off = 1'b0;
        repeat (2) @(negedge clock);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
